// File: rtl/fft_radix2_butterfly_if.sv
// Sample/result bundle for the radix-2 butterfly: three packed complex
// operands in, two packed complex results out, valid strobes in each direction.
interface fft_radix2_butterfly_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] W;
  logic             out_valid;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;

  modport master (
    output in_valid, A, B, W,
    input  out_valid, out0, out1
  );

  modport slave (
    input  in_valid, A, B, W,
    output out_valid, out0, out1
  );
endinterface

// File: rtl/fft_radix2_butterfly.sv
// Two-stage pipelined radix-2 DIT butterfly: out0 = A + W*B, out1 = A - W*B.
// Define BUTTERFLY_SAT_EN to saturate each output component instead of wrapping.
module fft_radix2_butterfly #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fft_radix2_butterfly_if.slave   bus
);
  localparam int HALF = WIDTH / 2;
  localparam int FRAC = HALF - 1;

`ifdef BUTTERFLY_SAT_EN
  localparam logic signed [HALF+2:0] SAT_MAX = {4'b0000, {(HALF-1){1'b1}}};
  localparam logic signed [HALF+2:0] SAT_MIN = {4'b1111, {(HALF-1){1'b0}}};
`endif

  // Narrow a HALF+3-bit sum back to one output component.
  function automatic logic [HALF-1:0] reduce_comp(input logic signed [HALF+2:0] x);
`ifdef BUTTERFLY_SAT_EN
    logic [HALF-1:0] r;
    if (x > SAT_MAX) begin
      r = SAT_MAX[HALF-1:0];
    end else if (x < SAT_MIN) begin
      r = SAT_MIN[HALF-1:0];
    end else begin
      r = x[HALF-1:0];
    end
    return r;
`else
    return x[HALF-1:0];
`endif
  endfunction

  logic signed [HALF-1:0]   br_s, bi_s, wr_s, wi_s;
  logic signed [2*HALF-1:0] prod_rr_s, prod_ii_s, prod_ri_s, prod_ir_s;
  logic                     unused_lsbs_s;

  logic                     v1_r;
  logic [WIDTH-1:0]         a_r;
  logic signed [HALF:0]     p_rr_r, p_ii_r, p_ri_r, p_ir_r;

  logic signed [HALF-1:0]   ar_s, ai_s;
  logic signed [HALF+1:0]   pr_s, pi_s;
  logic signed [HALF+2:0]   s0r_s, s0i_s, s1r_s, s1i_s;
  logic [WIDTH-1:0]         out0_s, out1_s;

  logic                     v2_r;
  logic [WIDTH-1:0]         out0_r, out1_r;

  // Stage-1 combinational: split operands and form the four full-precision products.
  always_comb begin
    br_s      = bus.B[WIDTH-1:HALF];
    bi_s      = bus.B[HALF-1:0];
    wr_s      = bus.W[WIDTH-1:HALF];
    wi_s      = bus.W[HALF-1:0];
    prod_rr_s = br_s * wr_s;
    prod_ii_s = bi_s * wi_s;
    prod_ri_s = br_s * wi_s;
    prod_ir_s = bi_s * wr_s;
  end

  // Fraction bits fall off in the floor shift; fold them so they are visibly consumed.
  assign unused_lsbs_s = ^{prod_rr_s[FRAC-1:0], prod_ii_s[FRAC-1:0],
                           prod_ri_s[FRAC-1:0], prod_ir_s[FRAC-1:0]};

  // Stage-1 register: A plus the four floor-shifted partials (top HALF+1 bits of each product).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      a_r    <= {WIDTH{1'b0}};
      p_rr_r <= {(HALF+1){1'b0}};
      p_ii_r <= {(HALF+1){1'b0}};
      p_ri_r <= {(HALF+1){1'b0}};
      p_ir_r <= {(HALF+1){1'b0}};
    end else begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        a_r    <= bus.A;
        p_rr_r <= prod_rr_s[2*HALF-1:FRAC];
        p_ii_r <= prod_ii_s[2*HALF-1:FRAC];
        p_ri_r <= prod_ri_s[2*HALF-1:FRAC];
        p_ir_r <= prod_ir_s[2*HALF-1:FRAC];
      end
    end
  end

  // Stage-2 combinational: complex product, then butterfly sums with no cross-field carry.
  always_comb begin
    ar_s   = a_r[WIDTH-1:HALF];
    ai_s   = a_r[HALF-1:0];
    pr_s   = $signed({p_rr_r[HALF], p_rr_r}) - $signed({p_ii_r[HALF], p_ii_r});
    pi_s   = $signed({p_ri_r[HALF], p_ri_r}) + $signed({p_ir_r[HALF], p_ir_r});
    s0r_s  = $signed({{3{ar_s[HALF-1]}}, ar_s}) + $signed({pr_s[HALF+1], pr_s});
    s0i_s  = $signed({{3{ai_s[HALF-1]}}, ai_s}) + $signed({pi_s[HALF+1], pi_s});
    s1r_s  = $signed({{3{ar_s[HALF-1]}}, ar_s}) - $signed({pr_s[HALF+1], pr_s});
    s1i_s  = $signed({{3{ai_s[HALF-1]}}, ai_s}) - $signed({pi_s[HALF+1], pi_s});
    out0_s = {reduce_comp(s0r_s), reduce_comp(s0i_s)};
    out1_s = {reduce_comp(s1r_s), reduce_comp(s1i_s)};
  end

  // Stage-2 register: results load only with a valid partial set, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      out0_r <= {WIDTH{1'b0}};
      out1_r <= {WIDTH{1'b0}};
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        out0_r <= out0_s;
        out1_r <= out1_s;
      end
    end
  end

  assign bus.out_valid = v2_r;
  assign bus.out0      = out0_r;
  assign bus.out1      = out1_r;
endmodule

// File: tb/tb_fft_radix2_butterfly.sv
// Bench for fft_radix2_butterfly: integer reference model plus literal vectors,
// one negedge compare process, and an asynchronous mid-stream reset.
module tb_fft_radix2_butterfly;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    int          due;
    logic [31:0] e0;
    logic [31:0] e1;
    bit          has_lit;
    logic [31:0] l0;
    logic [31:0] l1;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last0 = 32'd0;
  logic [31:0] last1 = 32'd0;

  fft_radix2_butterfly_if #(.WIDTH(32)) bus ();

  fft_radix2_butterfly #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cplx(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  function automatic logic [15:0] red(input longint x);
`ifdef BUTTERFLY_SAT_EN
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
`endif
    return x[15:0];
  endfunction

  // Reference: plain integer arithmetic, each product floored by 2^15 separately.
  function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] w, input bit minus);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
    pr = ((br * wr) >>> 15) - ((bi * wi) >>> 15);
    pi = ((br * wi) >>> 15) + ((bi * wr) >>> 15);
    if (minus) return {red(ar - pr), red(ai - pi)};
    return {red(ar + pr), red(ai + pi)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                       input bit has_lit, input logic [31:0] l0, input logic [31:0] l1);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.W = w;
    e.due = cyc + 2;
    e.e0 = bfly(a, b, w, 1'b0);
    e.e1 = bfly(a, b, w, 1'b1);
    e.has_lit = has_lit;
    e.l0 = l0;
    e.l1 = l1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      bus.W = $urandom;
    end
  endtask

  // Compare on every falling edge: reset zeros, due results, or held values.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out0", bus.out0, 32'd0);
      chk("rst_out1", bus.out1, 32'd0);
    end else if (q.size() != 0 && q[0].due == cyc) begin
      chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("out0_model", bus.out0, q[0].e0);
      chk("out1_model", bus.out1, q[0].e1);
      if (q[0].has_lit) begin
        chk("out0_literal", bus.out0, q[0].l0);
        chk("out1_literal", bus.out1, q[0].l1);
      end
      last0 = q[0].e0;
      last1 = q[0].e1;
      void'(q.pop_front());
    end else begin
      chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("hold_out0", bus.out0, last0);
      chk("hold_out1", bus.out1, last1);
    end
  end

  logic [31:0] va, vb, w1, w2, w3, w4, big, ovf0, ovf1, mn;

  initial begin
    va  = cplx(10, 5);
    vb  = cplx(20, 15);
    w1  = cplx(32767, 0);
    w2  = cplx(0, -32767);
    w3  = cplx(-32768, 0);
    w4  = cplx(0, 32767);
    big = cplx(32767, 0);
    mn  = cplx(-32768, -32768);
`ifdef BUTTERFLY_SAT_EN
    ovf0 = cplx(32767, 0);
`else
    ovf0 = cplx(-3, 0);
`endif
    ovf1 = cplx(1, 0);

    bus.in_valid = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    bus.W = 32'd0;

    chk("model_w1_out0", bfly(va, vb, w1, 1'b0), cplx(29, 19));
    chk("model_w1_out1", bfly(va, vb, w1, 1'b1), cplx(-9, -9));
    chk("model_w3_out0", bfly(va, vb, w3, 1'b0), cplx(-10, -10));
    chk("model_ovf_out0", bfly(big, big, big, 1'b0), ovf0);

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    drive(va, vb, w1, 1'b1, cplx(29, 19), cplx(-9, -9));
    idle(4);

    drive(va, vb, w1, 1'b1, cplx(29, 19), cplx(-9, -9));
    drive(va, vb, w2, 1'b1, cplx(25, -15), cplx(-5, 25));
    drive(va, vb, w3, 1'b1, cplx(-10, -10), cplx(30, 20));
    drive(va, vb, w4, 1'b1, cplx(-4, 24), cplx(24, -14));
    drive(big, big, big, 1'b1, ovf0, ovf1);
    drive(mn, mn, mn, 1'b0, 32'd0, 32'd0);
    drive(cplx(-32768, 32767), cplx(32767, -32768), cplx(-32768, 32767), 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) drive($urandom, $urandom, $urandom, 1'b0, 32'd0, 32'd0);
    idle(4);

    drive(va, vb, w1, 1'b1, cplx(29, 19), cplx(-9, -9));
    drive(va, vb, w2, 1'b1, cplx(25, -15), cplx(-5, 25));
    drive(va, vb, w3, 1'b1, cplx(-10, -10), cplx(30, 20));
    drive(va, vb, w4, 1'b1, cplx(-4, 24), cplx(24, -14));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    last0 = 32'd0;
    last1 = 32'd0;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_out0", bus.out0, 32'd0);
    chk("async_rst_out1", bus.out1, 32'd0);

    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(3);
    drive(va, vb, w2, 1'b1, cplx(25, -15), cplx(-5, 25));
    idle(4);

    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
